// File: rtl/lsu.sv
// ---------------------------------------------------------------------------
// lsu -- load/store unit between a core request port and a byte-masked RAM.
//
// Accepts one load or store at a time, of byte, half or word size, at any
// byte alignment. An access that crosses a word boundary is split into two
// RAM cycles (ACC1 for the low word, ACC2 for the next word, wrapping at the
// top of the address space). Load data is shifted back into place,
// sign- or zero-extended and held in RESP until the core takes it.
//
// Ports
//   i_clk, i_rst_n               clock, asynchronous active-low reset
//   i_req_*/o_req_ready          core request: we, size, unsigned, addr, wdata
//   o_rsp_*/i_rsp_ready          response: extended load data, split flag
//   o_rd1_addr/en/mask, i_rd1_data  RAM read port (combinational, masked data)
//   o_wr_addr/en/mask/data       RAM write port (data already lane-shifted)
// ---------------------------------------------------------------------------
module lsu #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_req_valid,
    output logic                  o_req_ready,
    input  logic                  i_req_we,
    input  logic [1:0]            i_req_size,
    input  logic                  i_req_unsigned,
    input  logic [ADDR_WIDTH-1:0] i_req_addr,
    input  logic [31:0]           i_req_wdata,
    output logic                  o_rsp_valid,
    input  logic                  i_rsp_ready,
    output logic [31:0]           o_rsp_rdata,
    output logic                  o_rsp_split,
    output logic [ADDR_WIDTH-1:0] o_rd1_addr,
    output logic                  o_rd1_en,
    output logic [3:0]            o_rd1_mask,
    input  logic [31:0]           i_rd1_data,
    output logic [ADDR_WIDTH-1:0] o_wr_addr,
    output logic                  o_wr_en,
    output logic [3:0]            o_wr_mask,
    output logic [31:0]           o_wr_data
);

    typedef enum logic [1:0] {IDLE, ACC1, ACC2, RESP} state_t;

    state_t state, state_nxt;

    // Registered request and the load data assembled from the RAM cycles.
    logic                  we_q;
    logic [1:0]            size_q;
    logic                  uns_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [31:0]           wdata_q;
    logic [31:0]           rdata_q;

    // Lane arithmetic, all derived from the registered request.
    logic [1:0]            off;
    logic [3:0]            smask;
    logic [7:0]            full;
    logic                  split;
    logic [ADDR_WIDTH-1:0] base_lo;
    logic [ADDR_WIDTH-1:0] base_hi;
    logic [5:0]            sh_lo;
    logic [5:0]            sh_hi;

    assign off     = addr_q[1:0];
    assign full    = {4'b0000, smask} << off;
    assign split   = |full[7:4];
    assign base_lo = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    // Second word wraps naturally at the top of the address space.
    assign base_hi = base_lo + ADDR_WIDTH'(4);
    assign sh_lo   = {1'b0, off, 3'b000};
    // Only used in ACC2, where off is never 0, so the shift is 8..24.
    assign sh_hi   = 6'd32 - sh_lo;

    always_comb begin
        case (size_q)
            2'd0:    smask = 4'h1;
            2'd1:    smask = 4'h3;
            default: smask = 4'hF;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'd0;
            uns_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            if (state == IDLE && i_req_valid) begin
                we_q    <= i_req_we;
                size_q  <= i_req_size;
                uns_q   <= i_req_unsigned;
                addr_q  <= i_req_addr;
                wdata_q <= i_req_wdata;
            end
            // RAM returns zeros in unmasked lanes, so the two halves can be
            // merged with a plain OR.
            if (state == ACC1) begin
                rdata_q <= i_rd1_data >> sh_lo;
            end else if (state == ACC2) begin
                rdata_q <= rdata_q | (i_rd1_data << sh_hi);
            end
        end
    end

    // RAM access shared by both ports; routed below by the access type.
    logic                  acc_en;
    logic [ADDR_WIDTH-1:0] acc_addr;
    logic [3:0]            acc_mask;
    logic [31:0]           acc_data;

    // NOTE: every output of this block gets a default first, so no path
    // through the case leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_nxt   = state;
        o_req_ready = 1'b0;
        o_rsp_valid = 1'b0;
        acc_en      = 1'b0;
        acc_addr    = '0;
        acc_mask    = 4'h0;
        acc_data    = 32'h0;
        case (state)
            IDLE: begin
                o_req_ready = 1'b1;
                if (i_req_valid) state_nxt = ACC1;
            end
            ACC1: begin
                acc_en    = 1'b1;
                acc_addr  = base_lo;
                acc_mask  = full[3:0];
                acc_data  = wdata_q << sh_lo;
                state_nxt = split ? ACC2 : RESP;
            end
            ACC2: begin
                acc_en    = 1'b1;
                acc_addr  = base_hi;
                acc_mask  = full[7:4];
                acc_data  = wdata_q >> sh_hi;
                state_nxt = RESP;
            end
            RESP: begin
                o_rsp_valid = 1'b1;
                if (i_rsp_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Enables come straight from the state, so an asynchronous reset drops
    // them immediately and a pending ACC2 write never happens.
    assign o_rd1_en   = acc_en & ~we_q;
    assign o_wr_en    = acc_en & we_q;
    assign o_rd1_addr = o_rd1_en ? acc_addr : '0;
    assign o_rd1_mask = o_rd1_en ? acc_mask : 4'h0;
    assign o_wr_addr  = o_wr_en  ? acc_addr : '0;
    assign o_wr_mask  = o_wr_en  ? acc_mask : 4'h0;
    assign o_wr_data  = o_wr_en  ? acc_data : 32'h0;

    logic [31:0] ext;

    always_comb begin
        case (size_q)
            2'd0:    ext = uns_q ? {24'h0, rdata_q[7:0]}
                                 : {{24{rdata_q[7]}}, rdata_q[7:0]};
            2'd1:    ext = uns_q ? {16'h0, rdata_q[15:0]}
                                 : {{16{rdata_q[15]}}, rdata_q[15:0]};
            default: ext = rdata_q;
        endcase
    end

    assign o_rsp_rdata = (o_rsp_valid && !we_q) ? ext : 32'h0;
    assign o_rsp_split = o_rsp_valid & split;

endmodule

// File: tb/tb_lsu.sv
// ---------------------------------------------------------------------------
// tb_lsu -- self-checking bench for lsu (ADDR_WIDTH = 8).
//
// A 64-word RAM model serves the LSU. A byte-array reference memory predicts
// load values, RAM accesses, split and latency; expectations are pushed to a
// scoreboard queue when a request is driven and popped at the response.
// ---------------------------------------------------------------------------
module tb_lsu;

    localparam int AW = 8;

    logic          clk;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [AW-1:0] req_addr;
    logic [31:0]   req_wdata;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [31:0]   rsp_rdata;
    logic          rsp_split;
    logic [AW-1:0] rd1_addr;
    logic          rd1_en;
    logic [3:0]    rd1_mask;
    logic [31:0]   rd1_data;
    logic [AW-1:0] wr_addr;
    logic          wr_en;
    logic [3:0]    wr_mask;
    logic [31:0]   wr_data;

    lsu #(.ADDR_WIDTH(AW)) dut (
        .i_clk          (clk),
        .i_rst_n        (rst_n),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_we       (req_we),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .o_rsp_valid    (rsp_valid),
        .i_rsp_ready    (rsp_ready),
        .o_rsp_rdata    (rsp_rdata),
        .o_rsp_split    (rsp_split),
        .o_rd1_addr     (rd1_addr),
        .o_rd1_en       (rd1_en),
        .o_rd1_mask     (rd1_mask),
        .i_rd1_data     (rd1_data),
        .o_wr_addr      (wr_addr),
        .o_wr_en        (wr_en),
        .o_wr_mask      (wr_mask),
        .o_wr_data      (wr_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- RAM model ----------------
    logic [31:0] mem [64];
    logic        do_preload;

    function automatic logic [31:0] lane_bits(input logic [3:0] m);
        return {{8{m[3]}}, {8{m[2]}}, {8{m[1]}}, {8{m[0]}}};
    endfunction

    assign rd1_data = rd1_en ? (mem[rd1_addr[7:2]] & lane_bits(rd1_mask)) : 32'h0;

    always @(posedge clk) begin
        if (do_preload) begin
            for (int w = 0; w < 64; w++) mem[w] <= 32'h0;
            mem[0]  <= 32'h44332211;
            mem[1]  <= 32'h88776655;
            mem[63] <= 32'hA1B2C3D4;
        end else if (wr_en) begin
            for (int b = 0; b < 4; b++)
                if (wr_mask[b]) mem[wr_addr[7:2]][8*b +: 8] <= wr_data[8*b +: 8];
        end
    end

    // ---------------- reference model and scoreboard ----------------
    logic [7:0] ref_b [256];

    typedef struct {
        logic [31:0] rdata;
        logic        split;
        int          lat;
        logic [7:0]  a1;
        logic [7:0]  a2;
        logic [3:0]  m1;
        logic [3:0]  m2;
        logic [31:0] d1;
        logic [31:0] d2;
    } exp_t;

    exp_t sb [$];

    int n_checks = 0;
    int n_passed = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp)
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        else
            n_passed++;
    endtask

    task automatic preload();
        for (int i = 0; i < 256; i++) ref_b[i] = 8'h00;
        {ref_b[3], ref_b[2], ref_b[1], ref_b[0]}         = 32'h44332211;
        {ref_b[7], ref_b[6], ref_b[5], ref_b[4]}         = 32'h88776655;
        {ref_b[255], ref_b[254], ref_b[253], ref_b[252]} = 32'hA1B2C3D4;
        @(negedge clk);
        do_preload = 1'b1;
        @(posedge clk);
        #1 do_preload = 1'b0;
    endtask

    // One RAM cycle: the port selected by we is active with the expected
    // address/mask (and data under the mask for stores); the other is idle.
    task automatic ram_check(input string tag, input logic we, input logic [7:0] a,
                             input logic [3:0] m, input logic [31:0] d);
        if (we) begin
            check({tag, "_wr_en"}, wr_en, 1);
            check({tag, "_rd_en"}, rd1_en, 0);
            check({tag, "_addr"}, wr_addr, a);
            check({tag, "_mask"}, wr_mask, m);
            check({tag, "_data"}, wr_data & lane_bits(m), d);
        end else begin
            check({tag, "_rd_en"}, rd1_en, 1);
            check({tag, "_wr_en"}, wr_en, 0);
            check({tag, "_addr"}, rd1_addr, a);
            check({tag, "_mask"}, rd1_mask, m);
        end
    endtask

    task automatic issue(input logic we, input logic [1:0] size, input logic uns,
                         input logic [7:0] addr, input logic [31:0] wdata, input int hold);
        exp_t        e;
        exp_t        x;
        int          n;
        int          k;
        logic [7:0]  a;
        logic [31:0] val;

        @(negedge clk);
        n = (size == 2'd0) ? 1 : (size == 2'd1) ? 2 : 4;
        e = '{rdata: 0, split: 0, lat: 0, a1: 0, a2: 0, m1: 0, m2: 0, d1: 0, d2: 0};
        e.a1 = addr & 8'hFC;
        e.a2 = e.a1 + 8'd4;
        val = 32'h0;
        for (int i = 0; i < n; i++) begin
            a = addr + 8'(i);
            val[8*i +: 8] = ref_b[a];
            if ((a & 8'hFC) == e.a1) begin
                e.m1[a[1:0]] = 1'b1;
                e.d1[8*a[1:0] +: 8] = wdata[8*i +: 8];
            end else begin
                e.m2[a[1:0]] = 1'b1;
                e.d2[8*a[1:0] +: 8] = wdata[8*i +: 8];
            end
            if (we) ref_b[a] = wdata[8*i +: 8];
        end
        e.split = (e.m2 != 4'h0);
        e.lat   = e.split ? 3 : 2;
        if (we)
            e.rdata = 32'h0;
        else if (n == 1)
            e.rdata = uns ? {24'h0, val[7:0]} : {{24{val[7]}}, val[7:0]};
        else if (n == 2)
            e.rdata = uns ? {16'h0, val[15:0]} : {{16{val[15]}}, val[15:0]};
        else
            e.rdata = val;
        sb.push_back(e);

        check("req_ready_idle", req_ready, 1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        req_addr     = addr;
        req_wdata    = wdata;
        @(posedge clk);
        #1 req_valid = 1'b0;

        x = sb[0];
        k = 0;
        do begin
            @(negedge clk);
            k++;
            check("en_exclusive", rd1_en & wr_en, 0);
            if (k == 1) begin
                check("req_ready_busy", req_ready, 0);
                ram_check("acc1", we, x.a1, x.m1, x.d1);
            end
            if (k == 2 && x.split) ram_check("acc2", we, x.a2, x.m2, x.d2);
        end while (!rsp_valid && k < 10);

        x = sb.pop_front();
        check("rsp_valid", rsp_valid, 1);
        check("latency", k, x.lat);
        check("rsp_rdata", rsp_rdata, x.rdata);
        check("rsp_split", rsp_split, x.split);
        check("resp_ram_idle", {rd1_en, wr_en, rd1_mask, wr_mask}, 0);

        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            check("hold_valid", rsp_valid, 1);
            check("hold_rdata", rsp_rdata, x.rdata);
            check("hold_split", rsp_split, x.split);
            check("hold_req_ready", req_ready, 0);
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rsp_ready = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'd0;
        req_unsigned = 1'b0;
        req_addr     = '0;
        req_wdata    = 32'h0;
        rsp_ready    = 1'b0;
        do_preload   = 1'b0;

        preload();
        @(negedge clk);
        check("rst_req_ready", req_ready, 1);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_rsp_rdata", rsp_rdata, 0);
        check("rst_rsp_split", rsp_split, 0);
        check("rst_ram", {rd1_en, wr_en, rd1_mask, wr_mask}, 0);
        check("rst_ram_addr", {rd1_addr, wr_addr}, 0);
        check("rst_wr_data", wr_data, 0);
        rst_n = 1'b1;

        // Directed scenarios on the preloaded image.
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0, 0);        // LW aligned
        issue(1'b0, 2'd0, 1'b0, 8'h07, 32'h0, 0);        // LB
        issue(1'b0, 2'd0, 1'b1, 8'h07, 32'h0, 0);        // LBU
        issue(1'b0, 2'd1, 1'b0, 8'h02, 32'h0, 0);        // LH
        issue(1'b0, 2'd2, 1'b0, 8'h03, 32'h0, 0);        // LW misaligned
        issue(1'b1, 2'd1, 1'b0, 8'h03, 32'h0000BEEF, 0); // SH misaligned
        check("sh_word0", mem[0], 32'hEF332211);
        check("sh_word1", mem[1], 32'h887766BE);
        issue(1'b0, 2'd2, 1'b0, 8'h04, 32'h0, 3);        // backpressure
        issue(1'b0, 2'd1, 1'b0, 8'hFF, 32'h0, 0);        // wrap to 0x00
        issue(1'b0, 2'd3, 1'b1, 8'h01, 32'h0, 0);        // size 3 as word

        // Random mix of loads and stores, sizes and alignments.
        for (int r = 0; r < 24; r++)
            issue(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
                  $urandom, r % 3);

        // Reset during ACC2 of a split store.
        preload();
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'd1;
        req_addr  = 8'h03;
        req_wdata = 32'h0000BEEF;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("rst_acc1_wr_en", wr_en, 1);
        @(negedge clk);
        check("rst_acc2_wr_en", wr_en, 1);
        rst_n = 1'b0;
        #1;
        check("rst_drop_wr_en", wr_en, 0);
        check("rst_drop_rd_en", rd1_en, 0);
        @(negedge clk);
        check("rst_word0", mem[0], 32'hEF332211);
        check("rst_word1", mem[1], 32'h88776655);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_release_ready", req_ready, 1);
        check("rst_release_valid", rsp_valid, 0);

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

endmodule

// File: doc/lsu.md
LSU -- requirements
Module: lsu

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, byte-address width; SHALL match the attached ram block. The data path is fixed at 32 bits with a 4-bit byte mask.
REQ-002 The block SHALL have one clock and an asynchronous, active-low reset. The ports SHALL be:
- i_clk, input, 1: the single clock; all state changes on its rising edge.
- i_rst_n, input, 1: asynchronous active-low reset.
- i_req_valid, input, 1: core request valid.
- o_req_ready, output, 1: LSU can accept a request.
- i_req_we, input, 1: 1 = store, 0 = load.
- i_req_size, input, 2: 0 = byte, 1 = half, 2 = word, 3 = treated as word.
- i_req_unsigned, input, 1: zero-extend the load result; 0 = sign-extend.
- i_req_addr, input, ADDR_WIDTH: byte address; any alignment is allowed.
- i_req_wdata, input, 32: store data, right-justified.
- o_rsp_valid, output, 1: response or completion valid.
- i_rsp_ready, input, 1: core accepts the response.
- o_rsp_rdata, output, 32: extended load data; 0 for stores.
- o_rsp_split, output, 1: the access needed two RAM cycles.
- o_rd1_addr, output, ADDR_WIDTH: word-aligned byte address to the RAM read port 1.
- o_rd1_en, output, 1: RAM read enable.
- o_rd1_mask, output, 4: RAM read byte mask.
- i_rd1_data, input, 32: combinational masked read data from the RAM.
- o_wr_addr, output, ADDR_WIDTH: word-aligned byte address to the RAM write port.
- o_wr_en, output, 1: RAM write enable.
- o_wr_mask, output, 4: RAM write byte mask.
- o_wr_data, output, 32: RAM write data, already lane-shifted.

Function
REQ-003 The FSM states SHALL be IDLE, ACC1, ACC2 and RESP. Only IDLE SHALL assert o_req_ready.
REQ-004 In IDLE, a request SHALL be accepted when i_req_valid and o_req_ready are both 1. The LSU SHALL register we, size, unsigned, addr and wdata, then go to ACC1.
REQ-005 Lane arithmetic uses off = addr[1:0] and smask = 0x1, 0x3 or 0xF by size. The 8-bit value full = smask << off SHALL be computed. The request is split when full[7:4] is not 0.
REQ-006 In ACC1 the LSU SHALL drive:
- address = {addr[AW-1:2], 2'b00};
- mask = full[3:0];
- wdata = wdata << 8*off.
It SHALL assert o_wr_en for a store, otherwise o_rd1_en. Read bytes (i_rd1_data >> 8*off) SHALL be captured at the clock edge. Next state is ACC2 if split, else RESP.
REQ-007 In ACC2 the LSU SHALL drive:
- address = ACC1 address + 4, wrapping modulo 2^ADDR_WIDTH;
- mask = full[7:4];
- wdata = wdata >> 8*(4-off).
It SHALL OR (i_rd1_data << 8*(4-off)) into the captured data, then go to RESP.
REQ-008 In RESP, o_rsp_valid SHALL be 1. o_rsp_rdata SHALL be the loaded value sign- or zero-extended from 8, 16 or 32 bits; it SHALL be 0 for stores. The LSU SHALL hold RESP and all rsp outputs stable until i_rsp_ready is 1, then go to IDLE.
REQ-009 Latency from the accept edge SHALL be: aligned, o_rsp_valid in the 2nd following cycle; split, in the 3rd. Back-to-back throughput SHALL be one request per 3 (aligned) or 4 (split) cycles.
REQ-010 RAM enables and masks SHALL be 0 outside ACC1 and ACC2. o_rd1_en and o_wr_en SHALL never both be 1.
REQ-011 A request presented while o_req_ready is 0 SHALL be ignored; the core holds it.

Reset
REQ-012 While i_rst_n is 0, the FSM SHALL be in IDLE. All registers and all outputs SHALL be 0, except o_req_ready, which is 1.
REQ-013 Reset asserted mid-operation SHALL immediately drop every RAM enable. A store half already written in ACC1 SHALL NOT be undone, and the ACC2 half SHALL NOT occur.

Verification
Preload for all scenarios: RAM word0 = 0x44332211, word1 = 0x88776655.
REQ-014 Aligned word load: LW at addr 0x04 -> ACC1 drives addr 0x04, mask 0xF; o_rsp_rdata = 0x88776655 valid 2 cycles after accept; o_rsp_split = 0.
REQ-015 Byte load extension: LB at 0x07 -> 0xFFFFFF88; LBU at 0x07 -> 0x00000088; LH at 0x02 -> 0x00004433.
REQ-016 Misaligned word load: LW at 0x03 -> ACC1 addr 0x00 mask 0x8, ACC2 addr 0x04 mask 0x7; rdata = 0x77665544, valid 3 cycles after accept; o_rsp_split = 1.
REQ-017 Misaligned half store: SH at 0x03 with wdata 0x0000BEEF ->
- write 1: addr 0x00, mask 0x8, data 0xEF000000;
- write 2: addr 0x04, mask 0x1, data 0x000000BE;
- result: word0 = 0xEF332211, word1 = 0x887766BE, rsp rdata = 0.
REQ-018 Backpressure and wrap:
- i_rsp_ready held 0 for 3 cycles -> o_rsp_valid and rdata held stable, o_req_ready stays 0.
- LH at 0xFF with ADDR_WIDTH 8 -> ACC2 addr 0x00.
REQ-019 Reset mid-store: i_rst_n driven 0 during ACC2 of REQ-017 -> o_wr_en is 0 at once; word1 stays 0x88776655; word0 = 0xEF332211; o_req_ready is 1 after release.
